// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared mode encodings, collector FSM states and default sizes
package gemm_pkg;

  localparam logic [1:0] GEMM = 2'b00;
  localparam logic [1:0] CNN  = 2'b01;
  localparam logic [1:0] DNN  = 2'b10;

  localparam int DEF_N  = 16;
  localparam int DEF_DW = 20;

  typedef enum logic [1:0] {
    COL_IDLE    = 2'b00,
    COL_COLLECT = 2'b01,
    COL_OUT     = 2'b10
  } col_state_t;

endpackage

// File: rtl/gemm_result_collector_if.sv
// rtl/gemm_result_collector_if.sv - drain input and row output bundle of the result collector
interface gemm_result_collector_if #(
  parameter int N  = 16,
  parameter int DW = 20,
  parameter int RW = 4
) ();

  logic [1:0]      state;
  logic [N*DW-1:0] col_result;
  logic [N-1:0]    col_valid;
  logic [N*DW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_row;
  logic            out_last;

  modport master (
    input  state, col_result, col_valid, out_ready,
    output out_data, out_valid, out_row, out_last
  );

  modport slave (
    output state, col_result, col_valid, out_ready,
    input  out_data, out_valid, out_row, out_last
  );

endinterface

// File: rtl/gemm_col_capture.sv
// rtl/gemm_col_capture.sv - one column's drain beat counter and N-deep row storage
module gemm_col_capture #(
  parameter int N  = 16,
  parameter int DW = 20,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic          valid,
  input  logic [DW-1:0] data,
  input  logic [RW-1:0] rd_idx,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          drop
);

  logic [RW:0]   cnt;
  logic [DW-1:0] mem [N];
  logic          full;
  logic          take;

  assign full = (cnt == (RW+1)'(N));
  assign take = en && valid && !full;
  assign drop = en && valid && full;
  // Lookahead: true when this column is full now or fills at the coming edge.
  assign done = full || (take && (cnt == (RW+1)'(N-1)));
  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (take) begin
      cnt <= cnt + 1'b1;
    end
  end

  // First drained beat belongs to the bottom row, so rows fill from N-1 down to 0.
  always_ff @(posedge clk) begin
    if (take) begin
      mem[RW'(N-1) - cnt[RW-1:0]] <= data;
    end
  end

endmodule

// File: rtl/gemm_result_collector.sv
// rtl/gemm_result_collector.sv - collects skewed per-column drain beats into a tile and emits it row by row
module gemm_result_collector
  import gemm_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  parameter int RW = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sync_reset,
  gemm_result_collector_if.master  bus,
  output logic                     busy,
  output logic                     overrun
);

  col_state_t    fsm, fsm_next;
  logic [RW-1:0] row_ptr;
  logic [N-1:0]  done_vec;
  logic [N-1:0]  drop_vec;
  logic          cap_en;
  logic          xfer;
  logic          last_xfer;
  logic          clear_cnt;

  assign cap_en    = (bus.state == GEMM) && (fsm != COL_OUT);
  assign xfer      = bus.out_valid && bus.out_ready;
  assign last_xfer = xfer && (row_ptr == RW'(N-1));
  assign clear_cnt = sync_reset || last_xfer;

  for (genvar c = 0; c < N; c++) begin : g_col
    gemm_col_capture #(.N(N), .DW(DW), .RW(RW)) u_col (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear_cnt),
      .en      (cap_en),
      .valid   (bus.col_valid[c]),
      .data    (bus.col_result[c*DW +: DW]),
      .rd_idx  (row_ptr),
      .rd_data (bus.out_data[c*DW +: DW]),
      .done    (done_vec[c]),
      .drop    (drop_vec[c])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm <= COL_IDLE;
    end else if (sync_reset) begin
      fsm <= COL_IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      COL_IDLE:    if (cap_en && |bus.col_valid) fsm_next = (&done_vec) ? COL_OUT : COL_COLLECT;
      COL_COLLECT: if (&done_vec) fsm_next = COL_OUT;
      COL_OUT:     if (last_xfer) fsm_next = COL_IDLE;
      default:     fsm_next = COL_IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = (fsm == COL_OUT);
    bus.out_last  = (fsm == COL_OUT) && (row_ptr == RW'(N-1));
    bus.out_row   = row_ptr;
    busy          = (fsm != COL_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_ptr <= '0;
    end else if (sync_reset) begin
      row_ptr <= '0;
    end else if (xfer) begin
      row_ptr <= last_xfer ? '0 : row_ptr + 1'b1;
    end
  end

  // Beats past a full column, or any GEMM beat while the tile is draining, are lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (sync_reset) begin
      overrun <= 1'b0;
    end else if ((|drop_vec) || ((fsm == COL_OUT) && (bus.state == GEMM) && (|bus.col_valid))) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gemm_result_collector.sv
// tb/tb_gemm_result_collector.sv - randomized self-checking bench against a tile reference model
module tb_gemm_result_collector;
  import gemm_pkg::*;

  localparam int N  = 16;
  localparam int DW = 20;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sync_reset = 1'b0;
  logic busy, overrun;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] val  [N][N+1];
  int            vcyc [N][N+1];
  int            nbeats [N];

  gemm_result_collector_if #(.N(N), .DW(DW), .RW(RW)) bus ();

  gemm_result_collector #(.N(N), .DW(DW), .RW(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_reset (sync_reset),
    .bus        (bus),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0: aligned, 1: column c starts c cycles late, 2: random start and gaps, random data
  task automatic build(input int kind, input bit extra);
    int t;
    for (int c = 0; c < N; c++) begin
      nbeats[c] = (extra && c == 3) ? N + 1 : N;
      t = (kind == 0) ? 0 : (kind == 1) ? c : int'($urandom_range(0, 6));
      if (extra && c == 15) t = 8;
      for (int k = 0; k < nbeats[c]; k++) begin
        if (kind == 2) while ($urandom_range(0, 3) == 0) t++;
        vcyc[c][k] = t;
        val[c][k]  = (kind == 2) ? DW'($urandom) : DW'(c * 100 + k);
        t++;
      end
    end
  endtask

  function automatic logic [N*DW-1:0] exp_row(input int r);
    logic [N*DW-1:0] row;
    for (int c = 0; c < N; c++) row[c*DW +: DW] = val[c][N-1-r];
    return row;
  endfunction

  task automatic collect();
    int last;
    int idx [N];
    last = 0;
    for (int c = 0; c < N; c++) begin
      idx[c] = 0;
      if (vcyc[c][N-1] > last) last = vcyc[c][N-1];
    end
    bus.state = GEMM;
    bus.out_ready = 1'b0;
    for (int t = 0; t <= last; t++) begin
      for (int c = 0; c < N; c++) begin
        bus.col_valid[c] = 1'b0;
        bus.col_result[c*DW +: DW] = DW'($urandom);
        if (idx[c] < nbeats[c] && vcyc[c][idx[c]] == t) begin
          bus.col_valid[c] = 1'b1;
          bus.col_result[c*DW +: DW] = val[c][idx[c]];
          idx[c]++;
        end
      end
      tick();
      check("out_valid_timing", (N*DW)'(bus.out_valid), (N*DW)'(t == last));
      if (t == 0) check("busy_after_first_beat", (N*DW)'(busy), (N*DW)'(1));
    end
    bus.col_valid = '0;
  endtask

  // ready_mode 0: always ready, 1: 1,0,0 repeating, 2: random
  task automatic drain(input int ready_mode, input bit pulse);
    int row;
    int cyc;
    row = 0;
    cyc = 0;
    while (row < N && cyc < 200) begin
      check("out_valid", (N*DW)'(bus.out_valid), (N*DW)'(1));
      check("out_row", (N*DW)'(bus.out_row), (N*DW)'(row));
      check("out_last", (N*DW)'(bus.out_last), (N*DW)'(row == N-1));
      check("out_data", bus.out_data, exp_row(row));
      bus.out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cyc % 3 == 0) : 1'($urandom);
      if (pulse && cyc == 1) begin
        bus.col_valid  = '1;
        bus.col_result = {N{DW'($urandom)}};
      end
      tick();
      bus.col_valid = '0;
      if (bus.out_ready) row++;
      cyc++;
    end
    bus.out_ready = 1'b0;
    if (row != N) check("drain_budget", (N*DW)'(row), (N*DW)'(N));
    check("out_valid_after_tile", (N*DW)'(bus.out_valid), (N*DW)'(0));
    check("busy_after_tile", (N*DW)'(busy), (N*DW)'(0));
  endtask

  initial begin
    bus.state      = GEMM;
    bus.col_valid  = '0;
    bus.col_result = '0;
    bus.out_ready  = 1'b0;

    tick();
    tick();
    check("reset_out_valid", (N*DW)'(bus.out_valid), (N*DW)'(0));
    check("reset_busy", (N*DW)'(busy), (N*DW)'(0));
    check("reset_overrun", (N*DW)'(overrun), (N*DW)'(0));
    check("reset_out_row", (N*DW)'(bus.out_row), (N*DW)'(0));
    check("reset_out_last", (N*DW)'(bus.out_last), (N*DW)'(0));
    rst = 1'b1;
    tick();

    build(0, 1'b0); collect(); drain(0, 1'b0);
    check("aligned_overrun", (N*DW)'(overrun), (N*DW)'(0));
    build(1, 1'b0); collect(); drain(1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      build(2, 1'b0); collect(); drain(2, 1'b0);
    end
    check("random_overrun", (N*DW)'(overrun), (N*DW)'(0));

    build(0, 1'b1); collect();
    check("overrun_extra_beat", (N*DW)'(overrun), (N*DW)'(1));
    drain(1, 1'b1);
    check("overrun_sticky", (N*DW)'(overrun), (N*DW)'(1));
    sync_reset = 1'b1; tick(); sync_reset = 1'b0;
    check("overrun_cleared", (N*DW)'(overrun), (N*DW)'(0));

    bus.state = CNN;
    for (int t = 0; t < N; t++) begin
      bus.col_valid  = '1;
      bus.col_result = {N{DW'($urandom)}};
      tick();
      check("mode_gate_busy", (N*DW)'(busy), (N*DW)'(0));
    end
    bus.col_valid = '0;
    check("mode_gate_overrun", (N*DW)'(overrun), (N*DW)'(0));
    check("mode_gate_out_valid", (N*DW)'(bus.out_valid), (N*DW)'(0));
    bus.state = GEMM;

    for (int t = 0; t < 8; t++) begin
      bus.col_valid  = '1;
      bus.col_result = {N{DW'($urandom)}};
      tick();
    end
    bus.col_valid = '0;
    check("partial_busy", (N*DW)'(busy), (N*DW)'(1));
    sync_reset = 1'b1; tick(); sync_reset = 1'b0;
    check("sync_reset_busy", (N*DW)'(busy), (N*DW)'(0));
    build(0, 1'b0); collect(); drain(2, 1'b0);

    build(2, 1'b0); collect();
    #3 rst = 1'b0;
    #1;
    check("async_rst_out_valid", (N*DW)'(bus.out_valid), (N*DW)'(0));
    check("async_rst_busy", (N*DW)'(busy), (N*DW)'(0));
    tick();
    rst = 1'b1;
    tick();
    build(2, 1'b0); collect(); drain(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gemm_result_collector.md
Name: gemm_result_collector

Overview:
- Receiving end of the systolic-array drain path. Sits below the bottom PE row and captures the per-column partial-sum streams (col_result qualified by gemm_valid2) shifted out after a GEMM pass.
- Reorders the captured beats into an N x N result tile.
- Presents the tile row by row on a valid/ready interface to the activation/writeback stage.

Parameters:
- N, 16, array dimension: number of columns and number of drain beats per column.
- DW, 20, width of one partial sum.
- RW, 4, row/beat index width, equal to clog2(N).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- sync_reset  input  1  synchronous clear of control state; tile contents are not cleared.
- state  input  2  array mode. 2'b00 = GEMM; any other value is CNN/DNN and no capture occurs.
- col_result  input  N*DW  drained partial sums. Column c occupies bits [c*DW +: DW].
- col_valid  input  N  per-column gemm_valid2. Columns may be skewed relative to each other.
- out_data  output  N*DW  one result row. Column c occupies bits [c*DW +: DW].
- out_valid  output  1  out_data holds a valid row.
- out_ready  input  1  downstream accepts the row.
- out_row  output  RW  index of the row currently on out_data.
- out_last  output  1  out_valid is high and out_row == N-1.
- busy  output  1  block is not IDLE.
- overrun  output  1  sticky: a beat was dropped.

Behaviour:
- Reset (rst low, asynchronous):
  - state register goes to IDLE; all per-column beat counters, the row pointer and overrun clear.
  - out_valid, out_last, busy and out_row are 0.
  - out_data reads the row-0 storage, which is don't-care.
- sync_reset (clk edge, lower priority than rst): same effect as reset on control state and flags; tile storage is retained. It also aborts a collection or an output transfer in progress.
- FSM states: IDLE, COLLECT, OUT.
  - IDLE -> COLLECT on the first cycle with state==2'b00 and any col_valid bit set. That beat is captured.
  - COLLECT -> OUT on the cycle after every column counter reaches N. out_valid rises exactly 1 cycle after the final beat is captured.
  - OUT -> IDLE on the cycle after the handshake for row N-1. out_valid is low in that cycle.
- Capture rule (IDLE/COLLECT, state==2'b00): for each column c with col_valid[c]=1 and cnt[c]<N:
  - store col_result[c] into tile[N-1-cnt[c]][c];
  - increment cnt[c].
  - The first beat from a column is bottom row N-1 and the last beat is row 0, matching the drain order of the array.
- Columns are independent: per-column skew of any amount and gaps inside a column's valid run are tolerated. The counter simply holds during a gap.
- Dropped beats:
  - col_valid[c]=1 with cnt[c]==N, or any col_valid bit during OUT -> beat discarded, overrun set.
  - col_valid while state != 2'b00 -> discarded silently; overrun is not set.
- overrun clears only on rst or sync_reset.
- Output handshake:
  - out_data = tile[row_ptr], out_row = row_ptr.
  - A transfer occurs when out_valid && out_ready; row_ptr then increments.
  - out_data and out_row must stay stable while out_valid && !out_ready.
  - Rows go out in order 0..N-1, at most one row per cycle. With out_ready held high, the whole tile drains in N cycles.
- Data handling: pass-through only, with no arithmetic or truncation. Values keep their signed 20-bit representation.
- Simultaneous events:
  - If the final beat of one column arrives together with other columns' beats, all of them are captured in that cycle.
  - A new-pass col_valid that coincides with the cycle the FSM returns to IDLE is treated as arriving during OUT, so it is dropped and overrun is set.

Decomposition:
- Shared package gemm_pkg holds:
  - mode encodings GEMM=2'b00, CNN=2'b01, DNN=2'b10;
  - FSM state constants COL_IDLE, COL_COLLECT, COL_OUT;
  - default N and DW.
- One natural sub-module, gemm_col_capture. It is instantiated N times and contains one column's beat counter, its storage of N x DW, and done/overrun outputs. The top level holds the FSM, the row mux and the handshake.

Test Plan:
- Aligned drain:
  - Stimulus: all 16 col_valid high for 16 cycles; column c beat k carries value c*100+k; out_ready=1.
  - Required: out_valid rises 1 cycle after the last beat; row r, column c = c*100+(15-r); out_last on row 15; busy falls afterwards.
- Skewed drain:
  - Stimulus: column c starts c cycles late, data as above.
  - Required: identical tile; out_valid rises 1 cycle after column 15's final beat, i.e. 31 cycles after the first beat.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,… during OUT.
  - Required: out_data/out_row stay stable while stalled; exactly 16 transfers, in order 0..15.
- Overrun:
  - Stimulus: column 3 gets a 17th beat; then col_valid pulses during OUT.
  - Required: both beats are discarded, overrun=1 sticks, and tile row 15 of column 3 is unchanged.
- Mode gating:
  - Stimulus: state=2'b01 with col_valid high for 16 cycles.
  - Required: block stays IDLE, busy=0, overrun=0.
- Reset mid-operation:
  - Stimulus: sync_reset after 8 beats; then a full aligned drain.
  - Required: FSM back to IDLE, counters restart, and the final tile is correct.
  - Stimulus: rst asserted during OUT.
  - Required: out_valid=0 immediately (asynchronously).
